// File: rtl/led_cmd_ctrl_if.sv
// Byte stream from the UART receiver into the LED command controller.
interface led_cmd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/led_cmd_ctrl.sv
// LED command controller.
// Hex-digit bytes light one LED, "S" sets all, "C" clears all. Any other
// byte runs an all-on/all-off error-flash burst, then restores the previous
// pattern. ESC aborts a burst early. Other bytes received during a burst are
// dropped and counted in a saturating counter.
// Optional macro LED_CMD_ACK_EN adds the ack_data/ack_valid response ports.
module led_cmd_ctrl #(
  parameter int unsigned NUM_LEDS      = 8,
  parameter int unsigned FLASH_CYCLES  = 100_000_000,
  parameter int unsigned FLASH_REPEATS = 4
) (
  input  logic                clk,
  input  logic                rst,
  led_cmd_ctrl_if.slave       rx,
  output logic [NUM_LEDS-1:0] leds,
  output logic                busy,
  output logic [7:0]          drop_cnt
`ifdef LED_CMD_ACK_EN
  ,
  output logic [7:0]          ack_data,
  output logic                ack_valid
`endif
);

  localparam int unsigned PW = $clog2(FLASH_CYCLES + 1);
  localparam int unsigned RW = $clog2(FLASH_REPEATS + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_CYCLES - 1);
  localparam logic [RW-1:0] REP_TOTAL  = RW'(FLASH_REPEATS);

  localparam logic [7:0] CMD_SET = 8'h53;
  localparam logic [7:0] CMD_CLR = 8'h43;
  localparam logic [7:0] CMD_ESC = 8'h1B;
  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_ERR = 8'h45;
  localparam logic [7:0] ACK_BSY = 8'h42;

  typedef enum logic [1:0] {
    IDLE,
    FLASH_ON,
    FLASH_OFF
  } state_t;

  state_t              state, state_n;
  logic [NUM_LEDS-1:0] leds_n;
  logic [NUM_LEDS-1:0] saved, saved_n;
  logic                busy_n;
  logic [7:0]          drop_n;
  logic [PW-1:0]       phase, phase_n;
  logic [RW-1:0]       rep, rep_n;
  logic [RW-1:0]       rep_inc;
  logic [7:0]          drop_inc;

  logic                hex_ok;
  logic [3:0]          hex_idx;
  logic                idx_ok;
  logic [NUM_LEDS-1:0] one_hot;
  logic                esc;

`ifdef LED_CMD_ACK_EN
  logic [7:0] ack_data_n;
  logic       ack_valid_n;
`endif

  // Decode the received byte into a hex index and the one-hot LED pattern.
  always_comb begin
    hex_ok  = 1'b0;
    hex_idx = '0;
    if (rx.rx_data >= 8'h30 && rx.rx_data <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_idx = 4'(rx.rx_data - 8'h30);
    end else if (rx.rx_data >= 8'h41 && rx.rx_data <= 8'h46) begin
      hex_ok  = 1'b1;
      hex_idx = 4'(rx.rx_data - 8'h37);
    end else if (rx.rx_data >= 8'h61 && rx.rx_data <= 8'h66) begin
      hex_ok  = 1'b1;
      hex_idx = 4'(rx.rx_data - 8'h57);
    end
    idx_ok = hex_ok && ({1'b0, hex_idx} < 5'(NUM_LEDS));
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      one_hot[i] = (hex_idx == 4'(i));
    end
    esc      = rx.rx_valid && (rx.rx_data == CMD_ESC);
    drop_inc = (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
    rep_inc  = rep + RW'(1);
  end

  // Next-state and output logic for command decode and the flash burst.
  always_comb begin
    state_n = state;
    leds_n  = leds;
    saved_n = saved;
    busy_n  = busy;
    drop_n  = drop_cnt;
    phase_n = phase;
    rep_n   = rep;
`ifdef LED_CMD_ACK_EN
    ack_valid_n = 1'b0;
    ack_data_n  = ack_data;
`endif
    unique case (state)
      IDLE: begin
        if (rx.rx_valid) begin
          if (idx_ok) begin
            leds_n  = one_hot;
            saved_n = one_hot;
`ifdef LED_CMD_ACK_EN
            ack_valid_n = 1'b1;
            ack_data_n  = ACK_OK;
`endif
          end else if (rx.rx_data == CMD_SET) begin
            leds_n  = '1;
            saved_n = '1;
`ifdef LED_CMD_ACK_EN
            ack_valid_n = 1'b1;
            ack_data_n  = ACK_OK;
`endif
          end else if (rx.rx_data == CMD_CLR) begin
            leds_n  = '0;
            saved_n = '0;
`ifdef LED_CMD_ACK_EN
            ack_valid_n = 1'b1;
            ack_data_n  = ACK_OK;
`endif
          end else begin
            saved_n = leds;
            leds_n  = '1;
            busy_n  = 1'b1;
            phase_n = '0;
            rep_n   = '0;
            state_n = FLASH_ON;
`ifdef LED_CMD_ACK_EN
            ack_valid_n = 1'b1;
            ack_data_n  = ACK_ERR;
`endif
          end
        end
      end

      FLASH_ON, FLASH_OFF: begin
        if (esc) begin
          leds_n  = saved;
          busy_n  = 1'b0;
          phase_n = '0;
          rep_n   = '0;
          state_n = IDLE;
`ifdef LED_CMD_ACK_EN
          ack_valid_n = 1'b1;
          ack_data_n  = ACK_OK;
`endif
        end else begin
          // A byte is dropped even on the final terminal count; the restore
          // below proceeds independently of it.
          if (rx.rx_valid) begin
            drop_n = drop_inc;
`ifdef LED_CMD_ACK_EN
            ack_valid_n = 1'b1;
            ack_data_n  = ACK_BSY;
`endif
          end
          if (phase != PHASE_LAST) begin
            phase_n = phase + PW'(1);
          end else begin
            phase_n = '0;
            if (state == FLASH_ON) begin
              leds_n  = '0;
              state_n = FLASH_OFF;
            end else begin
              rep_n = rep_inc;
              if (rep_inc < REP_TOTAL) begin
                leds_n  = '1;
                state_n = FLASH_ON;
              end else begin
                rep_n   = '0;
                leds_n  = saved;
                busy_n  = 1'b0;
                state_n = IDLE;
              end
            end
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      leds     <= '0;
      saved    <= '0;
      busy     <= 1'b0;
      drop_cnt <= '0;
      phase    <= '0;
      rep      <= '0;
`ifdef LED_CMD_ACK_EN
      ack_data  <= '0;
      ack_valid <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      leds     <= leds_n;
      saved    <= saved_n;
      busy     <= busy_n;
      drop_cnt <= drop_n;
      phase    <= phase_n;
      rep      <= rep_n;
`ifdef LED_CMD_ACK_EN
      ack_data  <= ack_data_n;
      ack_valid <= ack_valid_n;
`endif
    end
  end

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Testbench for led_cmd_ctrl: a short-flash instance (FLASH_CYCLES=4) for
// command/burst/abort/reset behaviour and a long-flash instance
// (FLASH_CYCLES=2000) for drop-counter saturation.
module tb_led_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] leds1, leds2;
  logic       busy1, busy2;
  logic [7:0] drop1, drop2;
`ifdef LED_CMD_ACK_EN
  logic [7:0] ack_data1, ack_data2;
  logic       ack_valid1, ack_valid2;
`endif

  always #5 clk = ~clk;

  led_cmd_ctrl_if bus1 ();
  led_cmd_ctrl_if bus2 ();

  led_cmd_ctrl #(.NUM_LEDS(8), .FLASH_CYCLES(4), .FLASH_REPEATS(2)) dut1 (
    .clk(clk), .rst(rst), .rx(bus1.slave),
    .leds(leds1), .busy(busy1), .drop_cnt(drop1)
`ifdef LED_CMD_ACK_EN
    , .ack_data(ack_data1), .ack_valid(ack_valid1)
`endif
  );

  led_cmd_ctrl #(.NUM_LEDS(8), .FLASH_CYCLES(2000), .FLASH_REPEATS(2)) dut2 (
    .clk(clk), .rst(rst), .rx(bus2.slave),
    .leds(leds2), .busy(busy2), .drop_cnt(drop2)
`ifdef LED_CMD_ACK_EN
    , .ack_data(ack_data2), .ack_valid(ack_valid2)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    int         which;
    logic [7:0] leds;
    logic       busy;
    logic [7:0] drop;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] leds;
  } vec_t;

  task automatic check(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Push the expectation, drive one cycle of input, then pop and compare.
  task automatic step(int which, logic v, logic [7:0] d, logic [7:0] el,
                      logic eb, logic [7:0] ed, string name);
    exp_t e;
    e.name = name; e.which = which; e.leds = el; e.busy = eb; e.drop = ed;
    sb.push_back(e);
    if (which == 1) begin
      bus1.rx_valid = v; bus1.rx_data = d;
    end else begin
      bus2.rx_valid = v; bus2.rx_data = d;
    end
    @(posedge clk);
    @(negedge clk);
    bus1.rx_valid = 1'b0;
    bus2.rx_valid = 1'b0;
    e = sb.pop_front();
    if (e.which == 1) begin
      check({e.name, "_leds"}, leds1, e.leds);
      check({e.name, "_busy"}, busy1, e.busy);
      check({e.name, "_drop"}, drop1, e.drop);
    end else begin
      check({e.name, "_leds"}, leds2, e.leds);
      check({e.name, "_busy"}, busy2, e.busy);
      check({e.name, "_drop"}, drop2, e.drop);
    end
  endtask

  // Full burst on dut1 started by 'bad'; optional byte on the restore cycle.
  task automatic burst1(logic [7:0] bad, logic [7:0] saved, logic [7:0] drop,
                        logic last_byte);
    step(1, 1'b1, bad, 8'hFF, 1'b1, drop, "burst_start");
    for (int i = 1; i < 16; i++) begin
      step(1, 1'b0, 8'h00, ((i / 4) % 2 == 0) ? 8'hFF : 8'h00, 1'b1, drop,
           "burst_phase");
    end
    step(1, last_byte, 8'h71, saved, 1'b0,
         last_byte ? drop + 8'd1 : drop, "burst_restore");
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 8'h33, 8'h08};  // "3"
    tbl[1] = '{1'b0, 8'h35, 8'h08};  // "5" without strobe: ignored
    tbl[2] = '{1'b1, 8'h30, 8'h01};  // "0"
    tbl[3] = '{1'b1, 8'h37, 8'h80};  // "7": top LED
    tbl[4] = '{1'b1, 8'h53, 8'hFF};  // "S"
    tbl[5] = '{1'b1, 8'h43, 8'h00};  // "C"
    tbl[6] = '{1'b1, 8'h34, 8'h10};  // "4"
    tbl[7] = '{1'b0, 8'h78, 8'h10};  // "x" without strobe: no burst
    tbl[8] = '{1'b1, 8'h36, 8'h40};  // "6"

    rst = 1'b0;
    bus1.rx_valid = 1'b0; bus1.rx_data = 8'h00;
    bus2.rx_valid = 1'b0; bus2.rx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset_leds", leds1, 8'h00);
    check("reset_busy", busy1, 1'b0);
    check("reset_drop", drop1, 8'h00);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(1, tbl[i].v, tbl[i].d, tbl[i].leds, 1'b0, 8'h00, "table");
    end

    // "3" then "9" (index 9 out of range) flashes and restores 0x08.
    step(1, 1'b1, 8'h33, 8'h08, 1'b0, 8'h00, "cmd_3");
    burst1(8'h39, 8'h08, 8'h00, 1'b0);

    // "5" then "x": 16-cycle burst, restore 0x20.
    step(1, 1'b1, 8'h35, 8'h20, 1'b0, 8'h00, "cmd_5");
    burst1(8'h78, 8'h20, 8'h00, 1'b0);

    // "S", "?", drop "1" and "2", ESC aborts.
    step(1, 1'b1, 8'h53, 8'hFF, 1'b0, 8'h00, "cmd_S");
    step(1, 1'b1, 8'h3F, 8'hFF, 1'b1, 8'h00, "esc_burst_start");
    step(1, 1'b1, 8'h31, 8'hFF, 1'b1, 8'h01, "drop_1");
    step(1, 1'b1, 8'h32, 8'hFF, 1'b1, 8'h02, "drop_2");
    step(1, 1'b1, 8'h1B, 8'hFF, 1'b0, 8'h02, "esc_abort");
    step(1, 1'b1, 8'h43, 8'h00, 1'b0, 8'h02, "cmd_C");

    // ESC during the OFF phase restores the saved pattern immediately.
    step(1, 1'b1, 8'h35, 8'h20, 1'b0, 8'h02, "cmd_5b");
    step(1, 1'b1, 8'h3F, 8'hFF, 1'b1, 8'h02, "esc_off_start");
    for (int i = 1; i < 5; i++) begin
      step(1, 1'b0, 8'h00, (i < 4) ? 8'hFF : 8'h00, 1'b1, 8'h02, "esc_off_phase");
    end
    step(1, 1'b1, 8'h1B, 8'h20, 1'b0, 8'h02, "esc_off_abort");

    // Reset in FLASH_OFF aborts without restore.
    step(1, 1'b1, 8'h78, 8'hFF, 1'b1, 8'h02, "rst_burst_start");
    for (int i = 1; i < 6; i++) begin
      step(1, 1'b0, 8'h00, (i < 4) ? 8'hFF : 8'h00, 1'b1, 8'h02, "rst_burst_phase");
    end
    rst = 1'b0;
    step(1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "rst_midburst");
    rst = 1'b1;
    step(1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "rst_no_restore");

    // "a" is out of range for 8 LEDs; byte on the restore cycle is counted.
    burst1(8'h61, 8'h00, 8'h00, 1'b1);
    step(1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h01, "after_coincident");

    // Long-flash instance: 300 bytes while busy saturate the drop counter.
    step(2, 1'b1, 8'h33, 8'h08, 1'b0, 8'h00, "sat_cmd_3");
    step(2, 1'b1, 8'h3F, 8'hFF, 1'b1, 8'h00, "sat_start");
    for (int i = 1; i < 8000; i++) begin
      step(2, i <= 300, 8'h6B, ((i / 2000) % 2 == 0) ? 8'hFF : 8'h00, 1'b1,
           (i < 255) ? 8'(i) : 8'hFF, "sat_phase");
    end
    step(2, 1'b1, 8'h71, 8'h08, 1'b0, 8'hFF, "sat_restore");
    step(2, 1'b1, 8'h53, 8'hFF, 1'b0, 8'hFF, "sat_idle_cmd");

`ifdef LED_CMD_ACK_EN
    // Ack pulses: "2" -> K, "z" -> E, "1" while busy -> B.
    step(1, 1'b1, 8'h32, 8'h04, 1'b0, 8'h01, "ack_cmd_2");
    check("ack_k_valid", ack_valid1, 1'b1);
    check("ack_k_data", ack_data1, 8'h4B);
    step(1, 1'b0, 8'h00, 8'h04, 1'b0, 8'h01, "ack_gap1");
    check("ack_k_width", ack_valid1, 1'b0);
    step(1, 1'b1, 8'h7A, 8'hFF, 1'b1, 8'h01, "ack_bad_z");
    check("ack_e_valid", ack_valid1, 1'b1);
    check("ack_e_data", ack_data1, 8'h45);
    step(1, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h01, "ack_gap2");
    check("ack_e_width", ack_valid1, 1'b0);
    step(1, 1'b1, 8'h31, 8'hFF, 1'b1, 8'h02, "ack_busy_1");
    check("ack_b_valid", ack_valid1, 1'b1);
    check("ack_b_data", ack_data1, 8'h42);
    step(1, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h02, "ack_gap3");
    check("ack_b_width", ack_valid1, 1'b0);
    for (int i = 4; i < 16; i++) begin
      step(1, 1'b0, 8'h00, ((i / 4) % 2 == 0) ? 8'hFF : 8'h00, 1'b1, 8'h02,
           "ack_burst_phase");
    end
    step(1, 1'b0, 8'h00, 8'h04, 1'b0, 8'h02, "ack_restore");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
